// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1x3 router control path.
//   state_e       - router_fsm state encoding (3 bits).
//   ADDR_INVALID  - header address value that selects no output.
//   pick_by_addr  - returns the per-FIFO flag chosen by a 2-bit address.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

    // Flag of the FIFO addressed by addr; the invalid address selects nothing.
    function automatic logic pick_by_addr(input logic [1:0] addr, input logic [2:0] flags);
        logic sel;
        sel = 1'b0;
        case (addr)
            2'd0:    sel = flags[0];
            2'd1:    sel = flags[1];
            2'd2:    sel = flags[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if: signal bundle between router_fsm and its neighbours.
//   Source side  : pkt_valid, data_in (header address), busy.
//   FIFO side    : fifo_full, fifo_empty_0..2, soft_reset_0..2.
//   router_reg   : parity_done, low_pkt_valid in; detect_add, lfd_state,
//                  ld_state, laf_state, full_state, write_enb_reg,
//                  rst_int_reg out.
// modport slave  - the FSM itself.
// modport master - the surrounding logic driving the FSM.
interface router_fsm_if;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state,
        output full_state, write_enb_reg, rst_int_reg
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, write_enb_reg, rst_int_reg
    );

endinterface

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing control FSM of the 1x3 router.
// Ports:
//   clock  - system clock, rising edge.
//   resetn - asynchronous active-low reset (forces DECODE_ADDRESS, addr_q=0).
//   bus    - router_fsm_if.slave; all handshake, FIFO status and
//            router_reg control signals. All outputs are Moore decodes of
//            the state register (no input-to-output combinational path).
module router_fsm
    import router_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    router_fsm_if.slave   bus
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] addr_q;
    logic       sel_empty;
    logic       sel_soft_reset;
    logic       hdr_empty;

    // Status of the FIFO latched at header time (used after DECODE_ADDRESS).
    assign sel_empty      = pick_by_addr(addr_q,
                                         {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0});
    assign sel_soft_reset = pick_by_addr(addr_q,
                                         {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
    // Status of the FIFO addressed by the header byte currently on data_in.
    assign hdr_empty      = pick_by_addr(bus.data_in,
                                         {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0});

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && bus.pkt_valid)
                addr_q <= bus.data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sel_soft_reset) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && bus.data_in != ADDR_INVALID)
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty)
                        state_d = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    // A full FIFO takes precedence over end of packet.
                    if (bus.fifo_full)
                        state_d = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid)
                        state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full)
                        state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)
                        state_d = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid)
                        state_d = LOAD_PARITY;
                    else
                        state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) ||
                               (state_q == LOAD_PARITY) ||
                               (state_q == LOAD_AFTER_FULL);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: self-checking bench for router_fsm. Each step drives the
// inputs, pushes the state the design must reach on the next edge, and
// after the edge pops it and compares the full output vector against the
// decode table for that state.
module tb_router_fsm;
    import router_pkg::*;

    logic clock;
    logic resetn;

    router_fsm_if bus ();

    router_fsm dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks;
    int unsigned n_fail;
    state_e      exp_q[$];

    // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
    function automatic logic [7:0] exp_out(input state_e s);
        logic [7:0] v;
        v = 8'h00;
        case (s)
            DECODE_ADDRESS:     v = 8'b0100_0000;
            LOAD_FIRST_DATA:    v = 8'b1010_0000;
            LOAD_DATA:          v = 8'b0001_0010;
            WAIT_TILL_EMPTY:    v = 8'b1000_0000;
            FIFO_FULL_STATE:    v = 8'b1000_0100;
            LOAD_AFTER_FULL:    v = 8'b1000_1010;
            LOAD_PARITY:        v = 8'b1000_0010;
            CHECK_PARITY_ERROR: v = 8'b1000_0001;
            default:            v = 8'hxx;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                bus.laf_state, bus.full_state, bus.write_enb_reg, bus.rst_int_reg};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (busy,det,lfd,ld,laf,full,wen,rst)",
                     tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input state_e exp_state);
        state_e s;
        exp_q.push_back(exp_state);
        @(posedge clock);
        #1;
        s = exp_q.pop_front();
        check_eq(tag, dut_out(), exp_out(s));
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        idle_inputs();
        #12;
        check_eq("reset_outputs", dut_out(), exp_out(DECODE_ADDRESS));
        resetn = 1'b1;

        // Normal packet to FIFO 2.
        step("np_idle", DECODE_ADDRESS);
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step("np_header", LOAD_FIRST_DATA);
        bus.data_in   = 2'd1;
        for (int i = 0; i < 9; i++) step("np_payload", LOAD_DATA);
        bus.pkt_valid = 1'b0;
        step("np_parity", LOAD_PARITY);
        step("np_check", CHECK_PARITY_ERROR);
        step("np_done", DECODE_ADDRESS);

        // Busy FIFO 1, then full stall variants.
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 2'd1;
        bus.fifo_empty_1 = 1'b0;
        step("bf_wait", WAIT_TILL_EMPTY);
        step("bf_wait_hold", WAIT_TILL_EMPTY);
        bus.fifo_empty_1 = 1'b1;
        step("bf_lfd", LOAD_FIRST_DATA);
        step("bf_ld", LOAD_DATA);
        bus.fifo_full = 1'b1;
        step("fs_full", FIFO_FULL_STATE);
        step("fs_full_hold", FIFO_FULL_STATE);
        bus.fifo_full = 1'b0;
        step("fs_laf", LOAD_AFTER_FULL);
        step("fs_laf_to_ld", LOAD_DATA);
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        step("fs_full_wins", FIFO_FULL_STATE);
        bus.fifo_full = 1'b0;
        step("fs_laf2", LOAD_AFTER_FULL);
        bus.low_pkt_valid = 1'b1;
        step("fs_laf_to_lp", LOAD_PARITY);
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 1'b1;
        step("fs_lp_to_cpe", CHECK_PARITY_ERROR);
        step("fs_cpe_full", FIFO_FULL_STATE);
        bus.fifo_full = 1'b0;
        step("fs_laf3", LOAD_AFTER_FULL);
        bus.parity_done = 1'b1;
        step("fs_laf_parity_done", DECODE_ADDRESS);
        bus.parity_done = 1'b0;
        step("fs_idle", DECODE_ADDRESS);

        // Invalid address.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        step("inv_addr", DECODE_ADDRESS);
        step("inv_addr_hold", DECODE_ADDRESS);

        // Soft reset on an addr-0 packet; soft_reset_1 must be ignored.
        bus.data_in = 2'd0;
        step("sr_lfd", LOAD_FIRST_DATA);
        step("sr_ld", LOAD_DATA);
        bus.soft_reset_1 = 1'b1;
        step("sr_other_ignored", LOAD_DATA);
        bus.soft_reset_1 = 1'b0;
        bus.soft_reset_0 = 1'b1;
        step("sr_selected", DECODE_ADDRESS);
        bus.soft_reset_0 = 1'b0;
        bus.pkt_valid    = 1'b0;
        step("sr_idle", DECODE_ADDRESS);

        // Soft reset while waiting on FIFO 2.
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 2'd2;
        bus.fifo_empty_2 = 1'b0;
        step("sr_wait", WAIT_TILL_EMPTY);
        bus.soft_reset_2 = 1'b1;
        step("sr_wait_reset", DECODE_ADDRESS);
        bus.soft_reset_2 = 1'b0;
        bus.pkt_valid    = 1'b0;
        bus.fifo_empty_2 = 1'b1;
        step("sr_wait_idle", DECODE_ADDRESS);

        // Asynchronous reset during FIFO_FULL_STATE.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd0;
        step("ar_lfd", LOAD_FIRST_DATA);
        step("ar_ld", LOAD_DATA);
        bus.fifo_full = 1'b1;
        step("ar_full", FIFO_FULL_STATE);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("ar_async", dut_out(), exp_out(DECODE_ADDRESS));
        @(posedge clock);
        #1;
        check_eq("ar_held", dut_out(), exp_out(DECODE_ADDRESS));
        idle_inputs();
        resetn = 1'b1;
        step("ar_released", DECODE_ADDRESS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
